// File: rtl/galaxian_pkg.sv
// Shared score/wave constants, score FSM states and BCD helpers.
package galaxian_pkg;

  localparam int unsigned NUM_ALIENS        = 12;
  localparam int unsigned SCORE_DIGITS      = 6;
  localparam int unsigned BCD_W             = 4 * SCORE_DIGITS;
  localparam int unsigned CLEAR_HOLD_FRAMES = 120;

  localparam logic [BCD_W-1:0] POINTS_PER_HIT = 24'h000030;
  localparam logic [BCD_W-1:0] WAVE_BONUS     = 24'h000500;
  localparam logic [BCD_W-1:0] BCD_MAX        = 24'h999999;

  localparam logic [4:0] PENDING_MAX = 5'd31;

  typedef enum logic [2:0] {
    StIdle,
    StPlay,
    StAdd,
    StClear,
    StGameOver
  } score_state_t;

  // Magnitude compare of two BCD numbers, most significant digit first.
  function automatic logic bcd_gt(input logic [BCD_W-1:0] a, input logic [BCD_W-1:0] b);
    logic gt;
    logic done;
    gt   = 1'b0;
    done = 1'b0;
    for (int i = int'(SCORE_DIGITS) - 1; i >= 0; i--) begin
      if (!done && (a[4*i +: 4] != b[4*i +: 4])) begin
        gt   = a[4*i +: 4] > b[4*i +: 4];
        done = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/bcd_adder.sv
// Ripple-carry multi-digit BCD adder; sat_o flags a carry out of the top digit.
module bcd_adder
  import galaxian_pkg::*;
#(
  parameter int unsigned Digits = SCORE_DIGITS
) (
  input  logic [4*Digits-1:0] a_i,
  input  logic [4*Digits-1:0] b_i,
  output logic [4*Digits-1:0] sum_o,
  output logic                sat_o
);

  logic       carry;
  logic [4:0] digit;

  // Digit-serial add with decimal adjust; final carry means overflow past all-9s.
  always_comb begin
    carry = 1'b0;
    digit = '0;
    sum_o = '0;
    for (int i = 0; i < int'(Digits); i++) begin
      digit = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0000, carry};
      if (digit > 5'd9) begin
        digit = digit + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum_o[4*i +: 4] = digit[3:0];
    end
    sat_o = carry;
  end

endmodule

// File: rtl/score_keeper.sv
// Turns hit-count increments into a saturating BCD score, awards wave bonuses,
// sequences the between-wave reset and keeps the session high score.
module score_keeper
  import galaxian_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             game_start,
  input  logic             player_dead,
  input  logic             frame_tick,
  input  logic [3:0]       hit_count,
  output logic [BCD_W-1:0] score_bcd,
  output logic [BCD_W-1:0] high_score_bcd,
  output logic [7:0]       wave_num,
  output logic             wave_clear,
  output logic             wave_reset,
  output logic             game_active
);

  score_state_t state;
  logic [3:0]   prev_count;
  logic [4:0]   pending;
  logic         dead_latch;
  logic [6:0]   hold_cnt;

  logic [3:0]       hit_delta;
  logic [5:0]       pend_sum;
  logic [5:0]       pend_dec;
  logic [4:0]       pend_acc;
  logic [4:0]       pend_drain;
  logic [BCD_W-1:0] add_operand;
  logic [BCD_W-1:0] add_sum;
  logic             add_sat;
  logic [BCD_W-1:0] score_next;

  // New hits this cycle and the saturating pending totals with/without a drain.
  always_comb begin
    hit_delta   = (hit_count > prev_count) ? hit_count - prev_count : 4'd0;
    pend_sum    = {1'b0, pending} + {2'b00, hit_delta};
    pend_dec    = pend_sum - 6'd1;
    pend_acc    = (pend_sum > {1'b0, PENDING_MAX}) ? PENDING_MAX : pend_sum[4:0];
    pend_drain  = (pend_dec > {1'b0, PENDING_MAX}) ? PENDING_MAX : pend_dec[4:0];
    // Bonus is only ever added from PLAY; ADD always adds per-hit points.
    add_operand = (state == StPlay) ? WAVE_BONUS : POINTS_PER_HIT;
    score_next  = add_sat ? BCD_MAX : add_sum;
  end

  bcd_adder #(
    .Digits(SCORE_DIGITS)
  ) u_bcd_adder (
    .a_i  (score_bcd),
    .b_i  (add_operand),
    .sum_o(add_sum),
    .sat_o(add_sat)
  );

  // Score FSM with registered outputs; hit tracking and death latch run in every active state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= StIdle;
      prev_count     <= '0;
      pending        <= '0;
      dead_latch     <= 1'b0;
      hold_cnt       <= '0;
      score_bcd      <= '0;
      high_score_bcd <= '0;
      wave_num       <= '0;
      wave_clear     <= 1'b0;
      wave_reset     <= 1'b0;
      game_active    <= 1'b0;
    end else begin
      wave_clear <= 1'b0;
      if (state != StIdle) begin
        prev_count <= hit_count;
        if (player_dead) dead_latch <= 1'b1;
      end
      case (state)
        StIdle: begin
          if (game_start) begin
            score_bcd   <= '0;
            wave_num    <= 8'd1;
            prev_count  <= '0;
            pending     <= '0;
            game_active <= 1'b1;
            state       <= StPlay;
          end
        end
        StPlay: begin
          // Crediting outranks death, and death outranks the wave bonus.
          if (pend_acc != 5'd0) begin
            pending <= pend_acc;
            state   <= StAdd;
          end else if (dead_latch) begin
            game_active <= 1'b0;
            state       <= StGameOver;
          end else if (prev_count == 4'(NUM_ALIENS)) begin
            score_bcd  <= score_next;
            if (wave_num != 8'hFF) wave_num <= wave_num + 8'd1;
            wave_clear <= 1'b1;
            wave_reset <= 1'b1;
            hold_cnt   <= '0;
            state      <= StClear;
          end
        end
        StAdd: begin
          score_bcd <= score_next;
          pending   <= pend_drain;
          if (pend_drain == 5'd0) state <= StPlay;
        end
        StClear: begin
          pending <= pend_acc;
          if ((hold_cnt == 7'(CLEAR_HOLD_FRAMES)) && (hit_count == 4'd0)) begin
            wave_reset <= 1'b0;
            state      <= StPlay;
          end else if (frame_tick && (hold_cnt != 7'(CLEAR_HOLD_FRAMES))) begin
            hold_cnt <= hold_cnt + 7'd1;
          end
        end
        StGameOver: begin
          if (bcd_gt(score_bcd, high_score_bcd)) high_score_bcd <= score_bcd;
          dead_latch <= 1'b0;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
